// File: rtl/rca_eval_pkg.sv
// ---------------------------------------------------------------------------
// rca_eval_pkg
// Shared types and width helpers for the approximate ripple-carry adder
// error analyzer.
//   state_t          : sweep controller states
//   vec_w(n, sc)     : vector counter width (A, B and optionally Cin)
//   sum_w(n, sc)     : accumulated error-distance width
//   DEF_N            : default operand width of the adder under test
// ---------------------------------------------------------------------------
package rca_eval_pkg;

   localparam int DEF_N = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int vec_w(input int n, input int sweep_cin);
      return 2 * n + sweep_cin;
   endfunction

   // Worst case is every vector off by 2**(N+1)-1, i.e. roughly
   // 2**VEC_W * 2**(N+1), which fits in VEC_W + N + 1 bits.
   function automatic int sum_w(input int n, input int sweep_cin);
      return 3 * n + 1 + sweep_cin;
   endfunction

endpackage

// File: rtl/rca_error_analyzer_ed_calc.sv
// ---------------------------------------------------------------------------
// ed_calc
// Combinational reference adder and error-distance calculator.
//   a, b, cin : operands currently applied to the adder under test
//   s         : (N+1)-bit sum returned by the adder under test
//   ed        : |exact - s|, unsigned, N+1 bits
//   mismatch  : high when s differs from the exact sum
// ---------------------------------------------------------------------------
module ed_calc #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic [N:0]   s,
   output logic [N:0]   ed,
   output logic         mismatch
);

   logic [N:0] exact;

   // N+1 bits hold A+B+Cin without overflow.
   assign exact    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   assign ed       = (exact >= s) ? (exact - s) : (s - exact);
   assign mismatch = (exact != s);

endmodule

// File: rtl/rca_error_analyzer.sv
// ---------------------------------------------------------------------------
// rca_error_analyzer
// Sweeps every (A, B, Cin) vector onto an external adder, compares the
// returned sum with the exact sum and accumulates error metrics.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a sweep (IDLE or DONE only)
//   pause                : freeze the sweep while in RUN
//   dut_a, dut_b, dut_cin: stimulus to the adder under test
//   dut_s                : sum returned by the adder (combinational path)
//   busy, done           : RUN / DONE status
//   err_cnt, ed_sum      : erroneous vector count, summed error distance
//   ed_max, worst_*      : max error distance and first vector reaching it
// ---------------------------------------------------------------------------
module rca_error_analyzer
   import rca_eval_pkg::*;
#(
   parameter  int N         = DEF_N,
   parameter  int SWEEP_CIN = 1,
   localparam int VEC_W     = vec_w(N, SWEEP_CIN),
   localparam int SUM_W     = sum_w(N, SWEEP_CIN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   output logic [N-1:0]     dut_a,
   output logic [N-1:0]     dut_b,
   output logic             dut_cin,
   input  logic [N:0]       dut_s,
   output logic             busy,
   output logic             done,
   output logic [VEC_W:0]   err_cnt,
   output logic [SUM_W-1:0] ed_sum,
   output logic [N:0]       ed_max,
   output logic [N-1:0]     worst_a,
   output logic [N-1:0]     worst_b,
   output logic             worst_cin
);

   state_t           state, state_nxt;
   logic [VEC_W-1:0] v;
   logic             v_last;
   logic             clr;
   logic             smp;
   logic [N:0]       ed;
   logic             mismatch;

   // Vector layout, MSB first: A, B, then Cin in the LSB when swept.
   assign dut_a = v[VEC_W-1 -: N];
   assign dut_b = v[VEC_W-1-N -: N];

   generate
      if (SWEEP_CIN != 0) begin : g_cin
         assign dut_cin = v[0];
      end else begin : g_nocin
         assign dut_cin = 1'b0;
      end
   endgenerate

   assign v_last = &v;
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   ed_calc #(.N(N)) u_ed_calc (
      .a        (dut_a),
      .b        (dut_b),
      .cin      (dut_cin),
      .s        (dut_s),
      .ed       (ed),
      .mismatch (mismatch)
   );

   // Start edge only clears; the first sample happens on the following edge.
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      smp       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               clr       = 1'b1;
            end
         end
         RUN: begin
            if (!pause) begin
               smp = 1'b1;
               if (v_last) state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v         <= '0;
         err_cnt   <= '0;
         ed_sum    <= '0;
         ed_max    <= '0;
         worst_a   <= '0;
         worst_b   <= '0;
         worst_cin <= 1'b0;
      end else if (clr) begin
         v         <= '0;
         err_cnt   <= '0;
         ed_sum    <= '0;
         ed_max    <= '0;
         worst_a   <= '0;
         worst_b   <= '0;
         worst_cin <= 1'b0;
      end else if (smp) begin
         if (mismatch) begin
            err_cnt <= err_cnt + (VEC_W+1)'(1);
            ed_sum  <= ed_sum + SUM_W'(ed);
         end
         // Strict compare keeps the first vector that hit the maximum.
         if (ed > ed_max) begin
            ed_max    <= ed;
            worst_a   <= dut_a;
            worst_b   <= dut_b;
            worst_cin <= dut_cin;
         end
         // The all-ones vector is the last one; hold rather than wrap.
         if (!v_last) v <= v + VEC_W'(1);
      end
   end

endmodule

// File: tb/tb_rca_error_analyzer.sv
module tb_rca_error_analyzer;

   localparam int N     = 4;
   localparam int SC    = 1;
   localparam int VW    = 2 * N + SC;
   localparam int SW    = 3 * N + 1 + SC;
   localparam int TOTAL = 1 << VW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          pause;
   logic [N-1:0]  dut_a, dut_b;
   logic          dut_cin;
   logic [N:0]    dut_s;
   logic          busy, done;
   logic [VW:0]   err_cnt;
   logic [SW-1:0] ed_sum;
   logic [N:0]    ed_max;
   logic [N-1:0]  worst_a, worst_b;
   logic          worst_cin;

   int            n_assert;
   int            n_fail;
   int            mode;
   logic [N:0]    lut [TOTAL];

   longint        e_err, e_sum, e_max, e_wa, e_wb, e_wc;

   rca_error_analyzer #(.N(N), .SWEEP_CIN(SC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pause     (pause),
      .dut_a     (dut_a),
      .dut_b     (dut_b),
      .dut_cin   (dut_cin),
      .dut_s     (dut_s),
      .busy      (busy),
      .done      (done),
      .err_cnt   (err_cnt),
      .ed_sum    (ed_sum),
      .ed_max    (ed_max),
      .worst_a   (worst_a),
      .worst_b   (worst_b),
      .worst_cin (worst_cin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural models of the adder under test.
   // 0 exact, 1 LSB flipped, 2 carry-out dropped, 3 random lookup table.
   function automatic logic [N:0] adder_out(input int m, input int a, input int b,
                                            input int c, input logic [N:0] lv);
      int ex;
      ex = a + b + c;
      case (m)
         0:       return (N+1)'(ex);
         1:       return (N+1)'(ex ^ 1);
         2:       return (N+1)'(ex & ~(1 << N));
         default: return lv;
      endcase
   endfunction

   always_comb
      dut_s = adder_out(mode, int'(dut_a), int'(dut_b), int'(dut_cin),
                        lut[{dut_a, dut_b, dut_cin}]);

   // Reference metrics: walk every vector in sweep order with plain integers.
   task automatic model(input int m);
      int s, ex, d;
      e_err = 0; e_sum = 0; e_max = 0; e_wa = 0; e_wb = 0; e_wc = 0;
      for (int a = 0; a < (1 << N); a++)
         for (int b = 0; b < (1 << N); b++)
            for (int c = 0; c < 2; c++) begin
               ex = a + b + c;
               s  = int'(adder_out(m, a, b, c, lut[(a << (N+1)) | (b << 1) | c]));
               d  = (ex > s) ? ex - s : s - ex;
               if (d != 0) begin
                  e_err++;
                  e_sum += d;
               end
               if (d > e_max) begin
                  e_max = d; e_wa = a; e_wb = b; e_wc = c;
               end
            end
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag);
      chk({tag, ".err_cnt"},   longint'(err_cnt),   e_err);
      chk({tag, ".ed_sum"},    longint'(ed_sum),    e_sum);
      chk({tag, ".ed_max"},    longint'(ed_max),    e_max);
      chk({tag, ".worst_a"},   longint'(worst_a),   e_wa);
      chk({tag, ".worst_b"},   longint'(worst_b),   e_wb);
      chk({tag, ".worst_cin"}, longint'(worst_cin), e_wc);
   endtask

   task automatic fill_lut(input int m);
      for (int i = 0; i < TOTAL; i++) begin
         if (m == 3 && $urandom_range(0, 3) == 0)
            lut[i] = (N+1)'($urandom_range(0, (1 << (N+1)) - 1));
         else
            lut[i] = (N+1)'((i >> (N+1)) + ((i >> 1) & ((1 << N) - 1)) + (i & 1));
      end
   endtask

   // One full sweep. pause_at/pause_len: pause after that many edges past
   // the start edge (0 = raised together with start). start_at: re-pulse
   // start mid-run (0 = never).
   task automatic run_sweep(input string tag, input int pause_at, input int pause_len,
                            input int start_at);
      int cycles;
      @(negedge clk);
      start = 1'b1;
      if (pause_len > 0 && pause_at == 0) pause = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles = 0;
      chk({tag, ".busy_after_start"}, longint'(busy), 1);
      chk({tag, ".cleared_on_start"}, longint'(err_cnt) + longint'(ed_sum) + longint'(ed_max), 0);
      while (!done && cycles < TOTAL + 1000) begin
         @(posedge clk);
         #1;
         cycles++;
         if (pause_len > 0 && cycles == pause_at + pause_len) begin
            pause = 1'b0;
            chk({tag, ".frozen_vector"}, longint'({dut_a, dut_b, dut_cin}), pause_at);
         end else if (pause_len > 0 && cycles == pause_at) begin
            pause = 1'b1;
         end
         start = (start_at != 0 && cycles == start_at);
      end
      start = 1'b0;
      chk({tag, ".done"}, longint'(done), 1);
      chk({tag, ".latency"}, cycles, TOTAL + pause_len);
      check_results(tag);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      mode     = 0;
      start    = 1'b0;
      pause    = 1'b0;
      rst_n    = 1'b0;
      fill_lut(0);
      #12;
      chk("reset.busy", longint'(busy), 0);
      chk("reset.done", longint'(done), 0);
      chk("reset.vector", longint'({dut_a, dut_b, dut_cin}), 0);
      e_err = 0; e_sum = 0; e_max = 0; e_wa = 0; e_wb = 0; e_wc = 0;
      check_results("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // pause is ignored in IDLE
      pause = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      pause = 1'b0;
      chk("idle_pause.busy", longint'(busy), 0);

      mode = 0; model(0);
      run_sweep("exact", 0, 0, 0);

      mode = 1; model(1);
      run_sweep("xor_lsb", 0, 0, 0);

      mode = 2; model(2);
      run_sweep("no_carry", 0, 0, 0);
      repeat (20) @(posedge clk);
      #1;
      chk("no_carry_hold.done", longint'(done), 1);
      check_results("no_carry_hold");

      mode = 1; model(1);
      run_sweep("pause_mid", 200, 100, 0);

      fill_lut(3); mode = 3; model(3);
      run_sweep("rand1", 0, 0, 0);

      fill_lut(3); model(3);
      run_sweep("rand2_start_in_run", 0, 0, 50);
      run_sweep("rand2_rerun_from_done", 0, 0, 0);

      // asynchronous reset in the middle of a sweep
      mode = 1; model(1);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      chk("pre_reset.err_cnt", longint'(err_cnt), 200);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset.busy", longint'(busy), 0);
      chk("async_reset.done", longint'(done), 0);
      chk("async_reset.err_cnt", longint'(err_cnt), 0);
      chk("async_reset.ed_sum", longint'(ed_sum), 0);
      chk("async_reset.ed_max", longint'(ed_max), 0);
      chk("async_reset.vector", longint'({dut_a, dut_b, dut_cin}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // start together with pause from IDLE: pause applies from the next edge
      run_sweep("after_reset_start_pause", 0, 10, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
